// File: rtl/gray_counter_param.sv
// Parametrised synchronous Gray-code counter with enable, direction, binary load,
// optional saturation, a terminal-count flag and a registered wrap pulse.
module gray_counter_param #(
    parameter int WIDTH    = 3,
    parameter int RST_VAL  = 0,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_gray,
    output logic [WIDTH-1:0] q_bin,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] bin_nxt;
    logic             wrap_nxt;
    logic             at_term;

    // Terminal value depends on the direction currently requested, not on en.
    assign at_term  = up_dn ? (bin_r == {WIDTH{1'b1}}) : (bin_r == {WIDTH{1'b0}});
    assign step_bin = up_dn ? (bin_r + WIDTH'(1)) : (bin_r - WIDTH'(1));

    always_comb begin
        bin_nxt  = bin_r;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (!(SATURATE && at_term)) begin
                bin_nxt  = step_bin;
                wrap_nxt = at_term;
            end
        end
    end

    // The Gray value is registered from the next binary value so q_gray is a
    // clean flop output and always sits in step with q_bin.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= RST_BIN;
            gray_r <= RST_GRAY;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= bin_nxt;
            gray_r <= bin_nxt ^ (bin_nxt >> 1);
            wrap_r <= wrap_nxt;
        end
    end

    assign q_bin  = bin_r;
    assign q_gray = gray_r;
    assign wrap   = wrap_r;
    assign tc     = at_term;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: four parameterisations driven one at a time,
// expected state pushed to a queue at drive time and popped after each edge.
module tb_gray_counter_param;

    logic clk;

    // u0: WIDTH=3 wrap; u1: WIDTH=4 saturate; u2: WIDTH=3 RST_VAL=3; u3: WIDTH=8
    logic       rst_a, en_a, ud_a, ld_a, tc_a, wr_a;
    logic [2:0] lv_a, qg_a, qb_a;
    logic       rst_b, en_b, ud_b, ld_b, tc_b, wr_b;
    logic [3:0] lv_b, qg_b, qb_b;
    logic       rst_c, en_c, ud_c, ld_c, tc_c, wr_c;
    logic [2:0] lv_c, qg_c, qb_c;
    logic       rst_d, en_d, ud_d, ld_d, tc_d, wr_d;
    logic [7:0] lv_d, qg_d, qb_d;

    gray_counter_param #(.WIDTH(3), .RST_VAL(0), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst_a), .en(en_a), .up_dn(ud_a), .load(ld_a), .load_val(lv_a),
        .q_gray(qg_a), .q_bin(qb_a), .tc(tc_a), .wrap(wr_a));
    gray_counter_param #(.WIDTH(4), .RST_VAL(0), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst(rst_b), .en(en_b), .up_dn(ud_b), .load(ld_b), .load_val(lv_b),
        .q_gray(qg_b), .q_bin(qb_b), .tc(tc_b), .wrap(wr_b));
    gray_counter_param #(.WIDTH(3), .RST_VAL(3), .SATURATE(1'b0)) u2 (
        .clk(clk), .rst(rst_c), .en(en_c), .up_dn(ud_c), .load(ld_c), .load_val(lv_c),
        .q_gray(qg_c), .q_bin(qb_c), .tc(tc_c), .wrap(wr_c));
    gray_counter_param #(.WIDTH(8), .RST_VAL(0), .SATURATE(1'b0)) u3 (
        .clk(clk), .rst(rst_d), .en(en_d), .up_dn(ud_d), .load(ld_d), .load_val(lv_d),
        .q_gray(qg_d), .q_bin(qb_d), .tc(tc_d), .wrap(wr_d));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          w_tab  [4] = '{3, 4, 3, 8};
    bit          sat_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] rv_tab [4] = '{16'd0, 16'd0, 16'd3, 16'd0};
    logic [15:0] m_bin  [4];
    logic [15:0] last_g [4];

    logic [16:0] exp_q[$];
    int check_cnt = 0;
    int pass_cnt  = 0;
    int wrap_obs  = 0;
    int wrap_exp  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        if (obs !== expv)
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        else
            pass_cnt++;
    endtask

    // Reference model: returns {wrap, next_bin}
    function automatic logic [16:0] model_next(input int w, input bit sat, input logic [15:0] rv,
                                               input logic [15:0] cur, input bit r, input bit l,
                                               input logic [15:0] lv, input bit e, input bit u);
        logic [15:0] mask;
        bit          term;
        mask = 16'((32'd1 << w) - 1);
        if (r) return {1'b0, rv};
        if (l) return {1'b0, lv & mask};
        if (!e) return {1'b0, cur};
        term = u ? (cur == mask) : (cur == 16'd0);
        if (term && sat) return {1'b0, cur};
        return {term, (u ? (cur + 16'd1) : (cur - 16'd1)) & mask};
    endfunction

    // driver: apply one cycle of stimulus to instance sel, then score its outputs
    task automatic cycle(input int sel, input bit r, input bit l, input logic [15:0] lv,
                         input bit e, input bit u);
        logic [16:0] res;
        logic [15:0] mask, cur, eb, ob, og;
        bit          ow, ot;
        mask = 16'((32'd1 << w_tab[sel]) - 1);
        case (sel)
            0: begin rst_a = r; ld_a = l; lv_a = lv[2:0]; en_a = e; ud_a = u; end
            1: begin rst_b = r; ld_b = l; lv_b = lv[3:0]; en_b = e; ud_b = u; end
            2: begin rst_c = r; ld_c = l; lv_c = lv[2:0]; en_c = e; ud_c = u; end
            default: begin rst_d = r; ld_d = l; lv_d = lv[7:0]; en_d = e; ud_d = u; end
        endcase
        cur = m_bin[sel];
        exp_q.push_back(model_next(w_tab[sel], sat_tab[sel], rv_tab[sel], cur, r, l, lv, e, u));
        @(posedge clk);
        #1;
        res = exp_q.pop_front();
        eb  = res[15:0];
        m_bin[sel] = eb;
        case (sel)
            0: begin ob = {13'd0, qb_a}; og = {13'd0, qg_a}; ow = wr_a; ot = tc_a; end
            1: begin ob = {12'd0, qb_b}; og = {12'd0, qg_b}; ow = wr_b; ot = tc_b; end
            2: begin ob = {13'd0, qb_c}; og = {13'd0, qg_c}; ow = wr_c; ot = tc_c; end
            default: begin ob = {8'd0, qb_d}; og = {8'd0, qg_d}; ow = wr_d; ot = tc_d; end
        endcase
        check_eq($sformatf("u%0d_bin", sel), {16'd0, ob}, {16'd0, eb});
        check_eq($sformatf("u%0d_gray", sel), {16'd0, og}, {16'd0, eb ^ (eb >> 1)});
        check_eq($sformatf("u%0d_wrap", sel), {31'd0, ow}, {31'd0, res[16]});
        check_eq($sformatf("u%0d_tc", sel), {31'd0, ot},
                 {31'd0, (u ? (eb == mask) : (eb == 16'd0))});
        if (!r && !l && e && (eb != cur))
            check_eq($sformatf("u%0d_one_bit", sel), $countones(og ^ last_g[sel]), 1);
        last_g[sel] = og;
        if (sel == 3) begin
            wrap_obs += int'(ow);
            wrap_exp += int'(res[16]);
        end
    endtask

    logic [2:0] g_tab [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                              3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        {rst_a, en_a, ud_a, ld_a} = 4'b1000; lv_a = '0;
        {rst_b, en_b, ud_b, ld_b} = 4'b1000; lv_b = '0;
        {rst_c, en_c, ud_c, ld_c} = 4'b1000; lv_c = '0;
        {rst_d, en_d, ud_d, ld_d} = 4'b1000; lv_d = '0;
        for (int i = 0; i < 4; i++) begin
            m_bin[i]  = '0;
            last_g[i] = '0;
        end

        // reset every instance and check reset state
        for (int s = 0; s < 4; s++) cycle(s, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
        check_eq("rst_gray_u2", {29'd0, qg_c}, 32'b010);

        // 1: up count on WIDTH=3 against the Gray table
        cycle(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check_eq("seq_gray_0", {29'd0, qg_a}, {29'd0, g_tab[0]});
        for (int i = 1; i < 9; i++) begin
            cycle(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
            check_eq($sformatf("seq_gray_%0d", i), {29'd0, qg_a}, {29'd0, g_tab[i]});
        end
        check_eq("wrap_after_7_0", {31'd0, wr_a}, 32'd1);
        cycle(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);

        // 2: down count from 0 through the 0 -> 7 wrap
        cycle(0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);

        // 3: load wins over en in the same cycle
        cycle(0, 1'b0, 1'b1, 16'd5, 1'b1, 1'b1);
        check_eq("load5_bin", {29'd0, qb_a}, 32'd5);
        check_eq("load5_gray", {29'd0, qg_a}, 32'b111);
        cycle(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
        check_eq("after_load_gray", {29'd0, qg_a}, 32'b101);

        // 4: saturation on WIDTH=4
        cycle(1, 1'b0, 1'b1, 16'd14, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
        check_eq("sat_hold_gray", {28'd0, qg_b}, 32'b1000);
        check_eq("sat_hold_tc", {31'd0, tc_b}, 32'd1);
        cycle(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        check_eq("sat_reverse", {28'd0, qb_b}, 32'd14);
        cycle(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);
        cycle(1, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0);

        // 5: mid-count reset with RST_VAL=3, then rst together with load
        for (int i = 0; i < 3; i++) cycle(2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
        check_eq("rv_pre_rst", {29'd0, qb_c}, 32'd6);
        cycle(2, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1);
        check_eq("rv_rst_bin", {29'd0, qb_c}, 32'd3);
        check_eq("rv_rst_gray", {29'd0, qg_c}, 32'b010);
        cycle(2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1);
        cycle(2, 1'b1, 1'b1, 16'd7, 1'b1, 1'b1);
        check_eq("rst_over_load", {29'd0, qb_c}, 32'd3);

        // 6: randomized traffic on WIDTH=8
        for (int i = 0; i < 2000; i++) begin
            cycle(3, 1'b0, ($urandom_range(0, 15) == 0), 16'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
        end
        check_eq("wrap_count", wrap_obs, wrap_exp);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
